mux_select_unit: RTL and testbench
==================================

Name: mux_select_unit

Overview:
- Bit-level selection primitive block for the ALU datapath.
- Provides a 2:1 mux path and a 4:1 mux path, each with a combinational output and a registered output.
- The 4:1 path is built as a two-level tree of 2:1 muxes. Wider muxes (8:1 and up) are composed from these combinational outputs.
- The registered outputs let ALU result-select stages be pipelined.

Parameters:
- WIDTH, 1, bit-width of each data lane. Every lane is selected identically and independently.

Ports:
- clk  input  1  rising-edge clock for registered outputs
- reset  input  1  asynchronous, active-high; clears registered outputs
- i0  input  WIDTH  2:1 data input, selected when sel2=0
- i1  input  WIDTH  2:1 data input, selected when sel2=1
- sel2  input  1  2:1 select
- i  input  4*WIDTH  4:1 data inputs; lane k occupies i[k*WIDTH +: WIDTH], k=0..3
- sel  input  2  4:1 select
- en  input  1  register load enable for both registered outputs
- out2  output  WIDTH  combinational 2:1 result
- out  output  WIDTH  combinational 4:1 result
- out2_q  output  WIDTH  registered out2
- out_q  output  WIDTH  registered out

Behaviour:
- Combinational paths (zero latency, no clock dependence):
  - out2 = sel2 ? i1 : i0.
  - out = lane[sel] of i. sel=00 gives lane 0, 01 gives lane 1, 10 gives lane 2, 11 gives lane 3.
- 4:1 structure:
  - Two first-level 2:1 muxes driven by sel[0]: (lane0, lane1) and (lane2, lane3).
  - One second-level 2:1 mux driven by sel[1] selects between them.
  - Result is functionally identical to direct indexing.
- Combinational outputs are not affected by reset or en.
- Select with X/Z bits: outputs X in simulation. No masking and no default-to-zero.
- Registered paths:
  - While reset=1 (asynchronous, takes effect immediately without a clock edge): out_q=0 and out2_q=0.
  - On a rising clk edge with reset=0 and en=1: out_q <= out and out2_q <= out2, both sampled at that edge.
  - With en=0: both registers hold their value.
- Latency: registered outputs reflect the inputs one clk edge after sampling.
- Reset asserted mid-operation clears the registers immediately, regardless of en or clk.
- Reset deassertion coincident with a clk edge: that edge does not load. The first load happens on the next edge.
- Inputs and selects changing between edges: only the values present at the edge are captured. No glitch propagates to out_q or out2_q.
- Composition rule for the 8:1 use:
  - Two instances' out values are combined by a further 2:1 stage on sel[2].
  - sel[1:0] is shared by both 4:1 stages.
  - i[3:0] feeds the low instance and i[7:4] the high instance.
- No internal state besides the two output registers. No handshake.

Test Plan:
- WIDTH=1, i=4'b1010, sweep sel 00,01,10,11 -> out = 0,1,0,1 at each step with zero delay. Repeat with i=4'b0101 -> 1,0,1,0.
- i0=0, i1=1, sel2 toggled 0→1→0 -> out2 = 0,1,0. Then i0=1, i1=0 -> out2 = 1,0,1.
- 8:1 composition of two instances plus out2 stage, data 8'b1011_0101:
  - Sweep sel3 = 000..111 -> output 1,0,1,0,1,1,0,1 (bit sel3 of the data).
- Pipeline:
  - reset=1 -> out_q=0 and out2_q=0 immediately, without a clock edge.
  - Release reset, en=1, sel=11, i=4'b1000 -> out_q=1 after the next rising edge.
  - en=0, i=0 -> out_q stays 1 over 3 edges.
- Async reset mid-cycle: with out_q=1, assert reset between edges -> out_q=0 immediately. Deassert on an edge with en=1 -> no load on that edge; load on the following edge.
- WIDTH=8, lanes 0x11, 0x22, 0x33, 0x44:
  - sel=10 -> out=0x33.
  - i0=0xAA, i1=0x55, sel2=1 -> out2=0x55.
  - One edge with en=1 -> out_q=0x33, out2_q=0x55.

Source files
------------

// File: rtl/mux_select_unit.sv
// mux_select_unit
// ----------------
// Bit-level selection primitive for the ALU datapath. It has a 2:1 path and a
// 4:1 path. Each path has a zero-latency combinational result and a registered
// copy of that result, so ALU result-select stages can be pipelined. Wider
// muxes (8:1 and up) are built by combining the combinational outputs of
// several instances with a further 2:1 stage.
//
// Ports
//   clk     rising-edge clock for the registered outputs
//   reset   asynchronous, active-high; clears out_q and out2_q at once
//   i0, i1  2:1 data inputs (i0 when sel2=0, i1 when sel2=1)
//   sel2    2:1 select
//   i       4:1 data, lane k at i[k*WIDTH +: WIDTH], k = 0..3
//   sel     4:1 select
//   en      load enable shared by both output registers
//   out2    combinational 2:1 result
//   out     combinational 4:1 result
//   out2_q  out2 registered on clk when en=1
//   out_q   out registered on clk when en=1
module mux_select_unit #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   i0,
  input  logic [WIDTH-1:0]   i1,
  input  logic               sel2,
  input  logic [4*WIDTH-1:0] i,
  input  logic [1:0]         sel,
  input  logic               en,
  output logic [WIDTH-1:0]   out2,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out2_q,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] out_q_reg;
  logic [WIDTH-1:0] out2_q_reg;

  // Every bit lane is selected independently. The 4:1 path is a two-level tree
  // of 2:1 muxes. sel[0] picks within the pairs (lane0, lane1) and
  // (lane2, lane3), and sel[1] then picks between the two pairs. A select bit
  // of X or Z drives X through the ternaries and is not masked.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic lvl1_lo;
      logic lvl1_hi;

      assign lvl1_lo  = sel[0] ? i[1*WIDTH + gi] : i[0*WIDTH + gi];
      assign lvl1_hi  = sel[0] ? i[3*WIDTH + gi] : i[2*WIDTH + gi];
      assign out[gi]  = sel[1] ? lvl1_hi : lvl1_lo;

      assign out2[gi] = sel2 ? i1[gi] : i0[gi];
    end
  endgenerate

  // The output registers are the only state in this block. reset clears them
  // at once, without a clock edge. While reset is high, no edge loads them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q_reg  <= '0;
      out2_q_reg <= '0;
    end else if (en) begin
      out_q_reg  <= out;
      out2_q_reg <= out2;
    end
  end

  assign out_q  = out_q_reg;
  assign out2_q = out2_q_reg;

endmodule

// File: tb/tb_mux_select_unit.sv
module tb_mux_select_unit;

  localparam int W = 8;

  // Signal ids used by the scoreboard
  localparam int ID_OUT    = 0;
  localparam int ID_OUT2   = 1;
  localparam int ID_OUTQ   = 2;
  localparam int ID_OUT2Q  = 3;
  localparam int ID_MUX8   = 4;
  localparam int ID_W1OUT  = 5;
  localparam int ID_W1OUT2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main WIDTH=8 instance
  logic           reset;
  logic [W-1:0]   i0, i1;
  logic           sel2;
  logic [4*W-1:0] i;
  logic [1:0]     sel;
  logic           en;
  logic [W-1:0]   out2, out, out2_q, out_q;

  mux_select_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel2(sel2), .i(i), .sel(sel),
    .en(en), .out2(out2), .out(out), .out2_q(out2_q), .out_q(out_q)
  );

  // WIDTH=1 instances: lo/hi 4:1 stages plus a combiner (its 2:1 path) -> 8:1
  logic [3:0] w1_i_lo, w1_i_hi;
  logic [1:0] w1_sel;
  logic       w1_i0, w1_i1, w1_sel2;
  logic [2:0] sel3;
  logic lo_out, lo_out2, lo_out_q, lo_out2_q;
  logic hi_out, hi_out2, hi_out_q, hi_out2_q;
  logic c_out, c_out2, c_out_q, c_out2_q;

  mux_select_unit #(.WIDTH(1)) u_lo (
    .clk(clk), .reset(reset), .i0(w1_i0), .i1(w1_i1), .sel2(w1_sel2), .i(w1_i_lo),
    .sel(w1_sel), .en(1'b0), .out2(lo_out2), .out(lo_out), .out2_q(lo_out2_q), .out_q(lo_out_q)
  );
  mux_select_unit #(.WIDTH(1)) u_hi (
    .clk(clk), .reset(reset), .i0(1'b0), .i1(1'b0), .sel2(1'b0), .i(w1_i_hi),
    .sel(w1_sel), .en(1'b0), .out2(hi_out2), .out(hi_out), .out2_q(hi_out2_q), .out_q(hi_out_q)
  );
  mux_select_unit #(.WIDTH(1)) u_comb (
    .clk(clk), .reset(reset), .i0(lo_out), .i1(hi_out), .sel2(sel3[2]), .i(4'b0000),
    .sel(2'b00), .en(1'b0), .out2(c_out2), .out(c_out), .out2_q(c_out2_q), .out_q(c_out_q)
  );

  // Scoreboard
  typedef struct {
    string       tag;
    int          id;
    logic [63:0] expv;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  event  sample_ev;

  // Reference model state for the registered outputs
  logic [W-1:0] mq, mq2;

  function automatic logic [W-1:0] m_lane(input logic [4*W-1:0] v, input logic [1:0] s);
    logic [4*W-1:0] sh;
    sh = v >> (int'(s) * W);
    return sh[W-1:0];
  endfunction

  function automatic logic [63:0] probe(input int id);
    case (id)
      ID_OUT:    return 64'(out);
      ID_OUT2:   return 64'(out2);
      ID_OUTQ:   return 64'(out_q);
      ID_OUT2Q:  return 64'(out2_q);
      ID_MUX8:   return 64'(c_out2);
      ID_W1OUT:  return 64'(lo_out);
      ID_W1OUT2: return 64'(lo_out2);
      default:   return 64'hDEAD;
    endcase
  endfunction

  task automatic push(input string tag, input int id, input logic [63:0] v);
    item_t it;
    it.tag = tag; it.id = id; it.expv = v;
    exp_q.push_back(it);
  endtask

  task automatic sample();
    -> sample_ev;
    #2;
  endtask

  // Push the full expected response of the W=8 instance from the model
  task automatic push_model(input string tag);
    push({tag, "_out"},    ID_OUT,   64'(m_lane(i, sel)));
    push({tag, "_out2"},   ID_OUT2,  64'(sel2 ? i1 : i0));
    push({tag, "_out_q"},  ID_OUTQ,  64'(mq));
    push({tag, "_out2_q"}, ID_OUT2Q, 64'(mq2));
  endtask

  task automatic tick();
    logic [W-1:0] nv, nv2;
    nv  = m_lane(i, sel);
    nv2 = sel2 ? i1 : i0;
    @(posedge clk);
    if (!reset && en) begin
      mq  = nv;
      mq2 = nv2;
    end
    #1;
  endtask

  // Monitor: compares every pending expectation when a response is presented
  initial begin
    item_t       it;
    logic [63:0] act;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        act = probe(it.id);
        checks++;
        if (act !== it.expv) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", it.tag, act, it.expv);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int exp_a[4] = '{0, 1, 0, 1};
    int exp_b[4] = '{1, 0, 1, 0};
    int exp_m[8] = '{1, 0, 1, 0, 1, 1, 0, 1};

    reset = 1'b1; en = 1'b0; i = '0; sel = 2'd0; i0 = '0; i1 = '0; sel2 = 1'b0;
    w1_i_lo = 4'd0; w1_i_hi = 4'd0; w1_sel = 2'd0; w1_i0 = 1'b0; w1_i1 = 1'b0;
    w1_sel2 = 1'b0; sel3 = 3'd0;
    mq = '0; mq2 = '0;
    #2;

    // Reset state, before any clock edge
    push("rst_out_q", ID_OUTQ, 64'd0);
    push("rst_out2_q", ID_OUT2Q, 64'd0);
    sample();

    // WIDTH=1 4:1 sweeps
    for (int s = 0; s < 4; s++) begin
      w1_i_lo = 4'b1010; w1_sel = 2'(s);
      push($sformatf("w1_1010_sel%0d", s), ID_W1OUT, 64'(exp_a[s]));
      sample();
    end
    for (int s = 0; s < 4; s++) begin
      w1_i_lo = 4'b0101; w1_sel = 2'(s);
      push($sformatf("w1_0101_sel%0d", s), ID_W1OUT, 64'(exp_b[s]));
      sample();
    end

    // WIDTH=1 2:1 toggles
    w1_i0 = 1'b0; w1_i1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w1_sel2 = (k == 1);
      push($sformatf("w1_out2_a%0d", k), ID_W1OUT2, (k == 1) ? 64'd1 : 64'd0);
      sample();
    end
    w1_i0 = 1'b1; w1_i1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w1_sel2 = (k == 1);
      push($sformatf("w1_out2_b%0d", k), ID_W1OUT2, (k == 1) ? 64'd0 : 64'd1);
      sample();
    end

    // 8:1 composition, data 8'b1011_0101
    w1_i_lo = 4'b0101; w1_i_hi = 4'b1011;
    for (int s = 0; s < 8; s++) begin
      sel3 = 3'(s); w1_sel = sel3[1:0];
      push($sformatf("mux8_sel%0d", s), ID_MUX8, 64'(exp_m[s]));
      sample();
    end

    // Pipeline: release reset, load lane 3 = 0x01
    @(negedge clk);
    reset = 1'b0; en = 1'b1; sel = 2'd3; i = 32'h01_00_00_00;
    push("pipe_out", ID_OUT, 64'h01);
    push("pipe_q_before", ID_OUTQ, 64'h00);
    sample();
    tick();
    push("pipe_q_load", ID_OUTQ, 64'h01);
    sample();
    en = 1'b0; i = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      push($sformatf("pipe_hold%0d", k), ID_OUTQ, 64'h01);
      sample();
    end

    // Asynchronous reset mid-cycle, then release just after an edge
    @(negedge clk);
    reset = 1'b1; mq = '0; mq2 = '0;
    push("async_rst_q", ID_OUTQ, 64'h00);
    push("async_rst_q2", ID_OUT2Q, 64'h00);
    sample();
    en = 1'b1; sel = 2'd3; i = 32'h01_00_00_00;
    @(posedge clk);
    #1 reset = 1'b0;
    push("rel_no_load", ID_OUTQ, 64'h00);
    sample();
    tick();
    push("rel_next_load", ID_OUTQ, 64'h01);
    sample();

    // WIDTH=8 lanes 0x11..0x44
    @(negedge clk);
    i = 32'h44_33_22_11; sel = 2'd2; i0 = 8'hAA; i1 = 8'h55; sel2 = 1'b1; en = 1'b1;
    push("w8_out", ID_OUT, 64'h33);
    push("w8_out2", ID_OUT2, 64'h55);
    sample();
    tick();
    push("w8_out_q", ID_OUTQ, 64'h33);
    push("w8_out2_q", ID_OUT2Q, 64'h55);
    sample();

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      i     = {$urandom(), $urandom()} >> 32;
      sel   = 2'($urandom_range(0, 3));
      i0    = 8'($urandom());
      i1    = 8'($urandom());
      sel2  = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 19) == 0);
      if (reset) begin
        mq = '0; mq2 = '0;
      end
      push_model($sformatf("rnd%0d", n));
      sample();
      tick();
    end

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
